// File: rtl/synth_pkg.sv
// Shared types and constants for the voice scheduler and its generator interface.
package synth_pkg;

  localparam int unsigned PHASE_W_DEF = 24;

  localparam logic [1:0] WAVE_SAW   = 2'd0;
  localparam logic [1:0] WAVE_TRI   = 2'd1;
  localparam logic [1:0] WAVE_SINE  = 2'd2;
  localparam logic [1:0] WAVE_NOISE = 2'd3;

  typedef enum logic [1:0] {StIdle, StPresent, StAccum} state_e;

endpackage

// File: rtl/voice_scheduler_if.sv
// Config write port and shared waveform generator bus of the voice scheduler.
interface voice_scheduler_if import synth_pkg::*; #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = PHASE_W_DEF
);
  localparam int unsigned VIDX_W = $clog2(NUM_VOICES);

  logic              cfg_we;
  logic [VIDX_W-1:0] cfg_voice;
  logic [PHASE_W-1:0] cfg_freq;
  logic [1:0]        cfg_wave;
  logic              cfg_on;

  logic [7:0]        saw_in;
  logic [7:0]        tri_in;
  logic [7:0]        sine_in;
  logic [7:0]        noise_in;
  logic [PHASE_W-1:0] gen_phase;
  logic              noise_step;

  modport master (
    output cfg_we, cfg_voice, cfg_freq, cfg_wave, cfg_on,
    output saw_in, tri_in, sine_in, noise_in,
    input  gen_phase, noise_step
  );

  modport slave (
    input  cfg_we, cfg_voice, cfg_freq, cfg_wave, cfg_on,
    input  saw_in, tri_in, sine_in, noise_in,
    output gen_phase, noise_step
  );
endinterface

// File: rtl/voice_regfile.sv
// Per-voice freq/wave/on/phase storage with a config write port and a phase update port.
module voice_regfile import synth_pkg::*; #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = PHASE_W_DEF,
  localparam int unsigned VIDX_W    = $clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [VIDX_W-1:0]  cfg_voice,
  input  logic [PHASE_W-1:0] cfg_freq,
  input  logic [1:0]         cfg_wave,
  input  logic               cfg_on,
  input  logic [VIDX_W-1:0]  rd_idx,
  output logic [PHASE_W-1:0] rd_freq,
  output logic [1:0]         rd_wave,
  output logic               rd_on,
  output logic [PHASE_W-1:0] rd_phase,
  input  logic [VIDX_W-1:0]  nxt_idx,
  output logic [PHASE_W-1:0] nxt_phase,
  input  logic               upd_en,
  input  logic [VIDX_W-1:0]  upd_idx,
  input  logic [PHASE_W-1:0] upd_phase
);

  logic [PHASE_W-1:0] freq_q  [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [1:0]         wave_q  [NUM_VOICES];
  logic               on_q    [NUM_VOICES];

  assign rd_freq   = freq_q[rd_idx];
  assign rd_wave   = wave_q[rd_idx];
  assign rd_on     = on_q[rd_idx];
  assign rd_phase  = phase_q[rd_idx];
  assign nxt_phase = phase_q[nxt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        freq_q[i]  <= '0;
        phase_q[i] <= '0;
        wave_q[i]  <= '0;
        on_q[i]    <= 1'b0;
      end
    end else begin
      if (upd_en) phase_q[upd_idx] <= upd_phase;
      if (cfg_we) begin
        freq_q[cfg_voice] <= cfg_freq;
        wave_q[cfg_voice] <= cfg_wave;
        on_q[cfg_voice]   <= cfg_on;
        // Disabling a voice resets its phase, winning over a same-cycle advance.
        if (!cfg_on) phase_q[cfg_voice] <= '0;
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes one shared waveform generator across NUM_VOICES voices per sample tick.
module voice_scheduler import synth_pkg::*; #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = PHASE_W_DEF,
  parameter int unsigned MIX_W      = 8 + $clog2(NUM_VOICES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_tick,
  voice_scheduler_if.slave bus,
  output logic [MIX_W-1:0] mix_out,
  output logic             mix_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned VIDX_W = $clog2(NUM_VOICES);
  localparam logic [VIDX_W-1:0] LastVoice = VIDX_W'(NUM_VOICES - 1);

  state_e             state_q;
  logic [VIDX_W-1:0]  vidx_q, nxt_idx;
  logic [MIX_W-1:0]   acc_q, acc_sum, mix_q;
  logic [PHASE_W-1:0] gen_phase_q, rd_freq, rd_phase, nxt_phase, upd_phase;
  logic [1:0]         rd_wave;
  logic               rd_on, upd_en;
  logic [7:0]         samp;
  logic               mix_valid_q, noise_step_q, busy_q, overrun_q;

  // Phase to present next: voice 0 when starting a frame, otherwise the following voice.
  assign nxt_idx   = (state_q == StIdle) ? '0 : vidx_q + 1'b1;
  assign upd_en    = (state_q == StAccum) && rd_on;
  assign upd_phase = rd_phase + rd_freq;

  voice_regfile #(
    .NUM_VOICES(NUM_VOICES),
    .PHASE_W   (PHASE_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (bus.cfg_we),
    .cfg_voice(bus.cfg_voice),
    .cfg_freq (bus.cfg_freq),
    .cfg_wave (bus.cfg_wave),
    .cfg_on   (bus.cfg_on),
    .rd_idx   (vidx_q),
    .rd_freq  (rd_freq),
    .rd_wave  (rd_wave),
    .rd_on    (rd_on),
    .rd_phase (rd_phase),
    .nxt_idx  (nxt_idx),
    .nxt_phase(nxt_phase),
    .upd_en   (upd_en),
    .upd_idx  (vidx_q),
    .upd_phase(upd_phase)
  );

  always_comb begin
    samp = '0;
    unique case (rd_wave)
      WAVE_SAW:   samp = bus.saw_in;
      WAVE_TRI:   samp = bus.tri_in;
      WAVE_SINE:  samp = bus.sine_in;
      WAVE_NOISE: samp = bus.noise_in;
      default:    samp = '0;
    endcase
  end

  assign acc_sum = acc_q + (rd_on ? MIX_W'(samp) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vidx_q       <= '0;
      acc_q        <= '0;
      mix_q        <= '0;
      gen_phase_q  <= '0;
      mix_valid_q  <= 1'b0;
      noise_step_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      mix_valid_q  <= 1'b0;
      noise_step_q <= 1'b0;
      if (sample_tick && state_q != StIdle) overrun_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (sample_tick) begin
            acc_q       <= '0;
            vidx_q      <= '0;
            gen_phase_q <= nxt_phase;
            busy_q      <= 1'b1;
            state_q     <= StPresent;
          end
        end
        StPresent: begin
          noise_step_q <= (vidx_q == '0);
          state_q      <= StAccum;
        end
        StAccum: begin
          acc_q <= acc_sum;
          if (vidx_q != LastVoice) begin
            vidx_q      <= vidx_q + 1'b1;
            gen_phase_q <= nxt_phase;
            state_q     <= StPresent;
          end else begin
            mix_q       <= acc_sum;
            mix_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gen_phase  = gen_phase_q;
  assign bus.noise_step = noise_step_q;
  assign mix_out        = mix_q;
  assign mix_valid      = mix_valid_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: 4 voices, saw driven from gen_phase[23:16].
module tb_voice_scheduler;
  import synth_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic [9:0] mix_out;
  logic       mix_valid, busy, overrun;
  logic [7:0] noise_val = 8'h33;

  int n_checks = 0;
  int n_pass   = 0;

  int          fr_mv, fr_ncnt, fr_ncyc;
  logic [15:0] fr_busy;
  logic [9:0]  fr_mix;
  logic [23:0] fr_gp1, fr_gp3;

  voice_scheduler_if #(.NUM_VOICES(4), .PHASE_W(24)) bus ();

  assign bus.saw_in   = bus.gen_phase[23:16];
  assign bus.tri_in   = 8'h55;
  assign bus.sine_in  = 8'hAA;
  assign bus.noise_in = noise_val;

  voice_scheduler #(.NUM_VOICES(4), .PHASE_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_tick(sample_tick),
    .bus        (bus),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cfg_write(input logic [1:0] v, input logic [23:0] f, input logic [1:0] w,
                           input logic on);
    bus.cfg_we    = 1'b1;
    bus.cfg_voice = v;
    bus.cfg_freq  = f;
    bus.cfg_wave  = w;
    bus.cfg_on    = on;
    step();
    bus.cfg_we = 1'b0;
  endtask

  // Runs cycles 0..15 of a frame from the current cycle, with optional disturbances.
  task automatic run_frame(input int tick2_cyc, input int cfg_cyc, input int rst_cyc,
                           input logic [1:0] cv, input logic [23:0] cf, input logic [1:0] cw,
                           input logic con);
    fr_mv = -1; fr_ncnt = 0; fr_ncyc = -1; fr_busy = '0; fr_mix = '0;
    fr_gp1 = '0; fr_gp3 = '0;
    sample_tick = 1'b1;
    for (int c = 1; c < 16; c++) begin
      step();
      if (mix_valid && fr_mv < 0) begin
        fr_mv  = c;
        fr_mix = mix_out;
      end
      if (bus.noise_step) begin
        fr_ncnt++;
        fr_ncyc = c;
      end
      fr_busy[c] = busy;
      if (c == 1) fr_gp1 = bus.gen_phase;
      if (c == 3) fr_gp3 = bus.gen_phase;
      sample_tick   = (c == tick2_cyc);
      bus.cfg_we    = (c == cfg_cyc);
      bus.cfg_voice = cv;
      bus.cfg_freq  = cf;
      bus.cfg_wave  = cw;
      bus.cfg_on    = con;
      if (c == rst_cyc) rst_n = 1'b0;
      else if (c == rst_cyc + 2) rst_n = 1'b1;
    end
    step();
  endtask

  task automatic std_checks(input string tag, input int exp_mix);
    check({tag, "_mv_cycle"}, 64'(fr_mv), 64'd9);
    check({tag, "_noise_cnt"}, 64'(fr_ncnt), 64'd1);
    check({tag, "_noise_cyc"}, 64'(fr_ncyc), 64'd2);
    check({tag, "_busy"}, 64'(fr_busy), 64'h01FE);
    check({tag, "_mix"}, 64'(fr_mix), 64'(exp_mix));
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_voice = '0; bus.cfg_freq = '0; bus.cfg_wave = '0;
    bus.cfg_on = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_outputs", 64'({bus.gen_phase, mix_out, mix_valid, bus.noise_step, busy,
                                 overrun}), 64'd0);
    end

    // Single saw voice ramps by one step per frame.
    cfg_write(2'd0, 24'h010000, WAVE_SAW, 1'b1);
    for (int k = 0; k < 4; k++) begin
      run_frame(-1, -1, -1, 2'd0, 24'd0, 2'd0, 1'b0);
      std_checks("saw", k);
      check("saw_gp1", 64'(fr_gp1), 64'(k * 32'h10000));
    end

    // All voices on noise at full scale.
    noise_val = 8'hFF;
    for (int v = 0; v < 4; v++) cfg_write(2'(v), 24'h010000, WAVE_NOISE, 1'b1);
    run_frame(-1, -1, -1, 2'd0, 24'd0, 2'd0, 1'b0);
    std_checks("noise", 1020);
    noise_val = 8'h33;

    // Phase wrap with a full-range increment, plus an overrun tick.
    cfg_write(2'd0, 24'd0, WAVE_SAW, 1'b0);
    cfg_write(2'd0, 24'hFFFFFF, WAVE_SAW, 1'b1);
    for (int v = 1; v < 4; v++) cfg_write(2'(v), 24'd0, WAVE_SAW, 1'b0);
    run_frame(-1, -1, -1, 2'd0, 24'd0, 2'd0, 1'b0);
    std_checks("wrap0", 0);
    check("wrap0_gp1", 64'(fr_gp1), 64'h0);
    run_frame(-1, -1, -1, 2'd0, 24'd0, 2'd0, 1'b0);
    std_checks("wrap1", 255);
    check("wrap1_gp1", 64'(fr_gp1), 64'hFFFFFF);
    check("overrun_before", 64'(overrun), 64'd0);
    run_frame(4, -1, -1, 2'd0, 24'd0, 2'd0, 1'b0);
    std_checks("ovr", 255);
    check("wrap2_gp1", 64'(fr_gp1), 64'hFFFFFE);
    check("overrun_set", 64'(overrun), 64'd1);
    run_frame(-1, -1, -1, 2'd0, 24'd0, 2'd0, 1'b0);
    std_checks("ovr_next", 255);
    check("wrap3_gp1", 64'(fr_gp1), 64'hFFFFFD);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Disable voice 1 during its own ACCUM: pre-write sample counts, phase is cleared.
    cfg_write(2'd0, 24'd0, WAVE_SAW, 1'b0);
    cfg_write(2'd1, 24'h020000, WAVE_SAW, 1'b1);
    run_frame(-1, -1, -1, 2'd0, 24'd0, 2'd0, 1'b0);
    std_checks("v1_a", 0);
    check("v1_a_gp3", 64'(fr_gp3), 64'h0);
    run_frame(-1, 4, -1, 2'd1, 24'd0, 2'd0, 1'b0);
    std_checks("v1_off", 2);
    check("v1_off_gp3", 64'(fr_gp3), 64'h020000);
    cfg_write(2'd1, 24'h020000, WAVE_SAW, 1'b1);
    run_frame(-1, -1, -1, 2'd0, 24'd0, 2'd0, 1'b0);
    std_checks("v1_clr", 0);
    check("v1_clr_gp3", 64'(fr_gp3), 64'h0);

    // Reset in cycle 5 aborts the frame.
    run_frame(-1, -1, 5, 2'd0, 24'd0, 2'd0, 1'b0);
    check("rst_no_valid", 64'(fr_mv), 64'(-1));
    check("rst_outputs", 64'({bus.gen_phase, mix_out, mix_valid, bus.noise_step, busy,
                              overrun}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
